// File: rtl/mcpu_core_pkg.sv
// mcpu_core_pkg: shared widths and the writeback queue entry type.
package mcpu_core_pkg;
  localparam int REG_NUM_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_NUM_W-1:0] rd_num;
    logic rd_we;
  } wb_entry_t;
endpackage

// File: rtl/mcpu_core_wb_queue.sv
// mcpu_core_wb_queue: in-order FIFO of wb entries; ent/vld age-ordered view only with MCPU_CORE_WB_BYPASS_EN.
module mcpu_core_wb_queue
  import mcpu_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  wb_entry_t din,
`ifdef MCPU_CORE_WB_BYPASS_EN
  output wb_entry_t [DEPTH-1:0] ent,
  output logic [DEPTH-1:0] vld,
`endif
  output wb_entry_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  wb_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign head = mem[rd_ptr];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
`ifdef MCPU_CORE_WB_BYPASS_EN
  // index 0 is the oldest entry, DEPTH-1 the youngest slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i] = mem[rd_ptr + AW'(i)];
      vld[i] = CW'(i) < cnt;
    end
  end
`endif
endmodule

// File: rtl/mcpu_core_stage_wb.sv
// mcpu_core_stage_wb: writeback queue, RF write port and retire counter; MCPU_CORE_WB_BYPASS_EN adds bypass lookup.
module mcpu_core_stage_wb
  import mcpu_core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic clkrst_core_clk,
  input  logic clkrst_core_rst,
  input  logic mem2wb_readyout,
  input  logic [DATA_W-1:0] mem2wb_in_data,
  input  logic [REG_NUM_W-1:0] mem2wb_in_rd_num,
  input  logic mem2wb_in_rd_we,
  output logic mem2wb_progress,
  input  logic wb2rf_busy,
  output logic wb2rf_we,
  output logic [REG_NUM_W-1:0] wb2rf_rd_num,
  output logic [DATA_W-1:0] wb2rf_data,
`ifdef MCPU_CORE_WB_BYPASS_EN
  input  logic [REG_NUM_W-1:0] byp_rs0_num,
  input  logic [REG_NUM_W-1:0] byp_rs1_num,
  output logic byp_rs0_hit,
  output logic byp_rs1_hit,
  output logic [DATA_W-1:0] byp_rs0_data,
  output logic [DATA_W-1:0] byp_rs1_data,
`endif
  output logic wb_empty,
  output logic [CNT_W-1:0] wb_retired
);
  wb_entry_t head;
  logic full, head_writes, pop;
`ifdef MCPU_CORE_WB_BYPASS_EN
  wb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0] vld;
`endif
  mcpu_core_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clkrst_core_clk),
    .rst(clkrst_core_rst),
    .push(mem2wb_progress),
    .pop(pop),
    .din('{data: mem2wb_in_data, rd_num: mem2wb_in_rd_num, rd_we: mem2wb_in_rd_we}),
`ifdef MCPU_CORE_WB_BYPASS_EN
    .ent(ent),
    .vld(vld),
`endif
    .head(head),
    .full(full),
    .empty(wb_empty)
  );
  assign head_writes = head.rd_we & (head.rd_num != '0);
  // non-writing heads drain even while another writer owns the port
  assign pop = ~wb_empty & (~wb2rf_busy | ~head_writes);
  assign mem2wb_progress = mem2wb_readyout & (~full | pop);
  assign wb2rf_we = ~wb_empty & head_writes & ~wb2rf_busy & ~clkrst_core_rst;
  assign wb2rf_rd_num = wb_empty ? '0 : head.rd_num;
  assign wb2rf_data = wb_empty ? '0 : head.data;
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) wb_retired <= '0;
    else wb_retired <= wb_retired + CNT_W'(pop);
  end
`ifdef MCPU_CORE_WB_BYPASS_EN
  // scanning oldest to youngest lets the youngest match win
  always_comb begin
    byp_rs0_hit = 1'b0;
    byp_rs1_hit = 1'b0;
    byp_rs0_data = '0;
    byp_rs1_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && ent[i].rd_we && byp_rs0_num != '0 && ent[i].rd_num == byp_rs0_num) begin
        byp_rs0_hit = 1'b1;
        byp_rs0_data = ent[i].data;
      end
      if (vld[i] && ent[i].rd_we && byp_rs1_num != '0 && ent[i].rd_num == byp_rs1_num) begin
        byp_rs1_hit = 1'b1;
        byp_rs1_data = ent[i].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mcpu_core_stage_wb.sv
// tb_mcpu_core_stage_wb: directed stimulus with a scoreboard of expected RF writes.
module tb_mcpu_core_stage_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic readyout = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0] in_rd = '0;
  logic in_we = 1'b0;
  logic progress;
  logic busy = 1'b0;
  logic rf_we;
  logic [4:0] rf_rd;
  logic [31:0] rf_data;
  logic empty;
  logic [31:0] retired;
`ifdef MCPU_CORE_WB_BYPASS_EN
  logic [4:0] rs0 = '0, rs1 = '0;
  logic hit0, hit1;
  logic [31:0] bd0, bd1;
`endif
  int total = 0;
  int bad = 0;
  int exp_ret = 0;
  int w;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  mcpu_core_stage_wb dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst(rst),
    .mem2wb_readyout(readyout),
    .mem2wb_in_data(in_data),
    .mem2wb_in_rd_num(in_rd),
    .mem2wb_in_rd_we(in_we),
    .mem2wb_progress(progress),
    .wb2rf_busy(busy),
    .wb2rf_we(rf_we),
    .wb2rf_rd_num(rf_rd),
    .wb2rf_data(rf_data),
`ifdef MCPU_CORE_WB_BYPASS_EN
    .byp_rs0_num(rs0),
    .byp_rs1_num(rs1),
    .byp_rs0_hit(hit0),
    .byp_rs1_hit(hit1),
    .byp_rs0_data(bd0),
    .byp_rs1_data(bd1),
`endif
    .wb_empty(empty),
    .wb_retired(retired)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rf_write: got unexpected write r%0d=%h want none", rf_rd, rf_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_rd, rf_data} !== e) begin
          bad++;
          $display("FAIL rf_write: got r%0d=%h want r%0d=%h", rf_rd, rf_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rd, input logic we, input logic [31:0] d, output int waits);
    readyout = 1'b1;
    in_rd = rd;
    in_we = we;
    in_data = d;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (progress) begin
        if (we && rd != 5'd0) exp_q.push_back({rd, d});
        exp_ret++;
        step();
        readyout = 1'b0;
        return;
      end
      waits++;
    end
    chk("send_timeout", 32'd1, 32'd0);
    readyout = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (empty) begin
        chk("retired", retired, exp_ret);
        return;
      end
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_progress", 32'(progress), 32'd0);
    chk("rst_retired", retired, 32'd0);
    step();
    // single result, one-cycle latency to the write port
    send(5'd5, 1'b1, 32'hDEADBEEF, w);
    chk("single_wait", w, 0);
    @(negedge clk);
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_rd", 32'(rf_rd), 32'd5);
    wait_empty();
    step();
    // busy stall with DEPTH=2
    busy = 1'b1;
    send(5'd1, 1'b1, 32'h0000_0101, w);
    chk("stall_w1", w, 0);
    send(5'd2, 1'b1, 32'h0000_0202, w);
    chk("stall_w2", w, 0);
    readyout = 1'b1;
    in_rd = 5'd3;
    in_we = 1'b1;
    @(negedge clk);
    chk("stall_full_prog0", 32'(progress), 32'd0);
    step();
    @(negedge clk);
    chk("stall_full_prog1", 32'(progress), 32'd0);
    step();
    busy = 1'b0;
    send(5'd3, 1'b1, 32'h0000_0303, w);
    chk("stall_w3", w, 0);
    wait_empty();
    step();
    // full queue with simultaneous push/pop
    busy = 1'b1;
    send(5'd10, 1'b1, 32'hA000_0000, w);
    send(5'd11, 1'b1, 32'hA000_0001, w);
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(5'(12 + i), 1'b1, 32'hB000_0000 + 32'(i), w);
      chk("full_pp_wait", w, 0);
    end
    wait_empty();
    step();
    // r0 and non-writing entries drain while busy
    busy = 1'b1;
    send(5'd0, 1'b1, 32'hCAFE_0000, w);
    send(5'd7, 1'b0, 32'hCAFE_0007, w);
    wait_empty();
    busy = 1'b0;
    step();
    // reset mid-operation
    busy = 1'b1;
    send(5'd9, 1'b1, 32'h0000_0909, w);
    send(5'd10, 1'b1, 32'h0000_0A0A, w);
    @(negedge clk);
    chk("pre_rst_empty", 32'(empty), 32'd0);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    busy = 1'b0;
    repeat (4) step();
    chk("post_rst_retired", retired, 32'd0);
`ifdef MCPU_CORE_WB_BYPASS_EN
    busy = 1'b1;
    send(5'd4, 1'b1, 32'h11, w);
    send(5'd4, 1'b1, 32'h22, w);
    rs0 = 5'd4;
    rs1 = 5'd0;
    @(negedge clk);
    chk("byp0_hit", 32'(hit0), 32'd1);
    chk("byp0_data", bd0, 32'h22);
    chk("byp1_hit", 32'(hit1), 32'd0);
    step();
    busy = 1'b0;
    wait_empty();
`endif
    repeat (2) step();
    chk("scoreboard_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mcpu_core_stage_wb.md
Name: mcpu_core_stage_wb

Overview:
Writeback stage, directly downstream of the memory stage. Accepts one result per cycle from the memory stage (data, destination register, write enable) into a small in-order queue. Drains the queue into the register-file write port, one entry per cycle, stalling while that port is busy. Also provides a retired-result counter and, optionally, bypass lookup of queued results.

Parameters:
DEPTH, 2, queue entries; power of two, >=2.
CNT_W, 32, width of the retired-result counter.

Ports:
clkrst_core_clk  in  1  core clock; all state updates on rising edge.
clkrst_core_rst  in  1  reset, synchronous, active-high.
mem2wb_readyout  in  1  memory stage has a completed result this cycle.
mem2wb_in_data  in  32  result data, already byte/half aligned by the memory stage.
mem2wb_in_rd_num  in  5  destination register.
mem2wb_in_rd_we  in  1  result writes a register.
mem2wb_progress  out  1  handshake fire; result accepted this cycle.
wb2rf_busy  in  1  register-file write port taken by another writer this cycle.
wb2rf_we  out  1  register-file write enable.
wb2rf_rd_num  out  5  register-file write address.
wb2rf_data  out  32  register-file write data.
wb_empty  out  1  queue empty.
wb_retired  out  CNT_W  count of entries popped since reset.

Behaviour:
- Reset (synchronous, clkrst_core_rst=1 at edge): rd/wr pointers=0, count=0, wb_retired=0. Outputs after reset: wb_empty=1, wb2rf_we=0, mem2wb_progress=0 (unless mem2wb_readyout=1 on the first cycle).
- Reset mid-operation drops all queued entries; no register-file write occurs in any cycle where clkrst_core_rst=1.
- pop = ~wb_empty & (~wb2rf_busy | ~head_writes), where head_writes = head.rd_we & (head.rd_num != 0).
- Entries that do not write (rd_we=0 or rd_num=0) pop even while busy. r0 is never written.
- mem2wb_progress = mem2wb_readyout & (count<DEPTH | pop). Full queue with a same-cycle pop accepts the new entry; count stays DEPTH.
- push = mem2wb_progress. On push, the entry {data, rd_num, rd_we} is written at wr_ptr and wr_ptr increments (mod DEPTH). On pop, rd_ptr increments (mod DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Write port (combinational from head): wb2rf_we = ~wb_empty & head_writes & ~wb2rf_busy; wb2rf_rd_num = head.rd_num; wb2rf_data = head.data. When empty, rd_num and data are driven 0.
- Latency: a result accepted at edge N is presented on the write port in cycle N+1; the RF write is committed at edge N+1 if not busy and the queue was empty.
- Empty queue does not bypass: there is no same-cycle input-to-RF path.
- wb_retired increments by 1 on each pop and wraps 2^CNT_W-1 -> 0.
- Ordering is strictly FIFO; two queued writes to the same register commit oldest first.

Optional Feature:
Macro MCPU_CORE_WB_BYPASS_EN.
- Defined: adds ports byp_rs0_num, byp_rs1_num (in, 5) and byp_rs0_hit, byp_rs1_hit (out, 1), byp_rs0_data, byp_rs1_data (out, 32).
- hit=1 when any valid queued entry has rd_we=1 and rd_num==rs_num!=0. Data comes from the youngest such entry. Purely combinational.
- Not defined: ports absent, no lookup logic; the upstream hazard logic must stall until wb_empty.

Decomposition:
- Shared package mcpu_core_pkg: REG_NUM_W=5, DATA_W=32, typedef wb_entry_t {data, rd_num, rd_we}.
- One natural sub-module: mcpu_core_wb_queue, a generic DEPTH-entry FIFO with simultaneous push/pop when full and full/empty flags. The stage wraps it with pop qualification, the write port and the counter.

Test Plan:
- Single result: readyout=1 for one cycle, data 0xDEADBEEF, rd=5, we=1, busy=0 -> progress=1; next cycle wb2rf_we=1, rd_num=5, data=0xDEADBEEF; wb_retired=1.
- Busy stall: 3 results to r1/r2/r3 back-to-back, busy=1 for 4 cycles -> progress drops after 2 accepts (DEPTH=2); writes r1, r2, r3 in order after busy falls; wb_retired=3.
- Full with simultaneous push/pop: queue full, busy=0, readyout=1 -> progress=1 every cycle, count stays 2, no lost or duplicated entries over 10 results.
- r0/no-write: rd=0 we=1 and rd=7 we=0 while busy=1 -> both pop, wb2rf_we never 1, wb_retired=2.
- Reset mid-operation: 2 entries queued, rst=1 one cycle -> wb_empty=1, wb2rf_we=0, wb_retired=0, queued writes never appear.
- Bypass (macro defined): queue r4=0x11 then r4=0x22, busy=1, byp_rs0_num=4 -> hit=1, data=0x22; byp_rs1_num=0 -> hit=0.
